// File: rtl/matmul_pkg.sv
// Shared constants and FSM state encoding for the 3x3 matrix-multiply controller.
package matmul_pkg;
  localparam int DW  = 8;
  localparam int N   = 3;
  localparam int OW  = 16;
  localparam int CAW = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/matmul_ctrl_dot3_pe.sv
// Three-term signed dot product with a registered, wrapped OW-bit result.
module dot3_pe import matmul_pkg::*; #(
  parameter int DW = matmul_pkg::DW,
  parameter int OW = matmul_pkg::OW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*DW-1:0]      a_row,
  input  logic [3*DW-1:0]      b_col,
  output logic signed [OW-1:0] sum
);
  // Accumulator is wide enough that the full sum never overflows before the wrap.
  localparam int AW = (OW > 2*DW + 2) ? OW : 2*DW + 2;

  function automatic logic signed [OW-1:0] wrap_ow(input logic signed [AW-1:0] x);
    return x[OW-1:0];
  endfunction

  logic signed [AW-1:0] prod [3];
  logic signed [AW-1:0] acc;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      prod[k] = AW'(signed'(a_row[k*DW +: DW])) * AW'(signed'(b_col[k*DW +: DW]));
    end
    acc = prod[0] + prod[1] + prod[2];
  end

  // ---- stage p2: registered result ----
  always_ff @(posedge clk) begin
    if (rst) sum <= '0;
    else     sum <= wrap_ow(acc);
  end
endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for C = A x B on 3x3 signed matrices: one row/column read per cycle,
// one result write per cycle two cycles later.
module matmul_ctrl import matmul_pkg::*; #(
  parameter int DW = matmul_pkg::DW,
  parameter int N  = matmul_pkg::N,
  parameter int OW = matmul_pkg::OW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a_rd_en,
  output logic [1:0]           a_rd_addr,
  input  logic [3*DW-1:0]      a_rd_data,
  output logic                 b_rd_en,
  output logic [1:0]           b_rd_addr,
  input  logic [3*DW-1:0]      b_rd_data,
  output logic                 c_wr_en,
  output logic [CAW-1:0]       c_wr_addr,
  output logic signed [OW-1:0] c_wr_data,
  output logic                 busy,
  output logic                 done
);
  localparam logic [1:0] LAST = 2'(N - 1);

  state_t           state;
  logic [1:0]       i, j;
  logic             vld_p0;
  logic             vld_p1;
  logic [CAW-1:0]   addr_p1;

  assign a_rd_en   = vld_p0;
  assign b_rd_en   = vld_p0;
  assign a_rd_addr = i;
  assign b_rd_addr = j;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      c_wr_en   <= 1'b0;
      c_wr_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // ---- stage p1: read data returning, address follows the read ----
      vld_p1  <= vld_p0;
      addr_p1 <= CAW'(i) * CAW'(N) + CAW'(j);
      // ---- stage p2: sum registered in dot3_pe, write strobe aligned ----
      c_wr_en   <= vld_p1;
      c_wr_addr <= addr_p1;
      done      <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          state  <= RUN;
          vld_p0 <= 1'b1;
          busy   <= 1'b1;
          i      <= '0;
          j      <= '0;
        end
        RUN: begin
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i      <= '0;
              vld_p0 <= 1'b0;
              state  <= DRAIN;
            end else begin
              i <= i + 2'd1;
            end
          end else begin
            j <= j + 2'd1;
          end
        end
        // Last write is in flight when the p2 strobe is up and nothing is behind it.
        DRAIN: if (c_wr_en && !vld_p1) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dot3_pe #(.DW(DW), .OW(OW)) u_pe (
    .clk   (clk),
    .rst   (rst),
    .a_row (a_rd_data),
    .b_col (b_rd_data),
    .sum   (c_wr_data)
  );
endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed-plus-random bench for matmul_ctrl against a plain-arithmetic matrix model.
module tb_matmul_ctrl;
  localparam int DW = 8;
  localparam int OW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 a_rd_en, b_rd_en, c_wr_en, busy, done;
  logic [1:0]           a_rd_addr, b_rd_addr;
  logic [3*DW-1:0]      a_rd_data = '0;
  logic [3*DW-1:0]      b_rd_data = '0;
  logic [3:0]           c_wr_addr;
  logic signed [OW-1:0] c_wr_data;

  matmul_ctrl #(.DW(DW), .N(3), .OW(OW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int Am [3][3];
  int Bm [3][3];
  int exp_c [9];

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    if (a_rd_en)
      for (int k = 0; k < 3; k++) a_rd_data[k*DW +: DW] <= DW'(Am[a_rd_addr][k]);
    if (b_rd_en)
      for (int k = 0; k < 3; k++) b_rd_data[k*DW +: DW] <= DW'(Bm[k][b_rd_addr]);
  end

  typedef struct { int cyc; int addr; int data; } wr_t;
  wr_t wq[$];
  int  dq[$];
  int  rq[$];
  bit  busy_hist [0:4095];

  always @(negedge clk) begin
    if (c_wr_en) wq.push_back('{cyc, int'(c_wr_addr), int'(c_wr_data)});
    if (done) dq.push_back(cyc);
    if (a_rd_en && b_rd_en) rq.push_back(cyc);
    if (cyc < 4096) busy_hist[cyc] = busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap16(input int x);
    logic signed [15:0] s;
    s = x[15:0];
    return int'(s);
  endfunction

  function automatic void compute_exp();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int acc = 0;
        for (int k = 0; k < 3; k++) acc += Am[r][k] * Bm[k][c];
        exp_c[r*3 + c] = wrap16(acc);
      end
  endfunction

  function automatic void fill_const(input int v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin Am[r][c] = v; Bm[r][c] = v; end
  endfunction

  function automatic void fill_rand();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        Am[r][c] = int'($urandom_range(0, 255)) - 128;
        Bm[r][c] = int'($urandom_range(0, 255)) - 128;
      end
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_at(input int t);
    wait_cyc(t);
    wq.delete(); dq.delete(); rq.delete();
    start = 1'b1;
    wait_cyc(t + 1);
    start = 1'b0;
  endtask

  task automatic check_op(input int t, input string tag);
    chk({tag, "_nwr"}, wq.size(), 9);
    for (int k = 0; k < 9 && k < wq.size(); k++) begin
      chk($sformatf("%s_wcyc%0d", tag, k), wq[k].cyc, t + 3 + k);
      chk($sformatf("%s_waddr%0d", tag, k), wq[k].addr, k);
      chk($sformatf("%s_wdata%0d", tag, k), wq[k].data, exp_c[k]);
    end
    chk({tag, "_nrd"}, rq.size(), 9);
    if (rq.size() > 0) chk({tag, "_rd_first"}, rq[0], t + 1);
    if (rq.size() > 0) chk({tag, "_rd_last"}, rq[rq.size()-1], t + 9);
    chk({tag, "_ndone"}, dq.size(), 1);
    if (dq.size() > 0) chk({tag, "_done_cyc"}, dq[0], t + 12);
    chk({tag, "_busy_t1"}, int'(busy_hist[t + 1]), 1);
    chk({tag, "_busy_t11"}, int'(busy_hist[t + 11]), 1);
    chk({tag, "_busy_t12"}, int'(busy_hist[t + 12]), 0);
  endtask

  task automatic run_full(input string tag);
    int t;
    compute_exp();
    t = cyc + 2;
    start_at(t);
    wait_cyc(t + 14);
    check_op(t, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int t;
    rst   = 1'b1;
    start = 1'b1;
    fill_const(0);
    wait_cyc(4);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'({a_rd_en, b_rd_en}), 0);
    chk("rst_wr_en", int'(c_wr_en), 0);
    chk("rst_addrs", int'({a_rd_addr, b_rd_addr, c_wr_addr}), 0);
    chk("rst_wdata", int'(c_wr_data), 0);
    start = 1'b0;
    rst   = 1'b0;
    wait_cyc(6);

    // Identity times 1..9
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        Am[r][c] = (r == c) ? 1 : 0;
        Bm[r][c] = r*3 + c + 1;
      end
    run_full("ident");
    if (wq.size() == 9) chk("ident_lit8", wq[8].data, 9);

    fill_const(127);
    run_full("p127");
    if (wq.size() > 0) chk("p127_lit", wq[0].data, -17149);

    fill_const(-128);
    run_full("m128");
    if (wq.size() > 0) chk("m128_lit", wq[0].data, -16384);

    // Start re-pulsed while busy and in the done cycle
    fill_rand();
    compute_exp();
    t = cyc + 2;
    start_at(t);
    wait_cyc(t + 5);  start = 1'b1;
    wait_cyc(t + 6);  start = 1'b0;
    wait_cyc(t + 12); start = 1'b1;
    wait_cyc(t + 13); start = 1'b0;
    wait_cyc(t + 30);
    check_op(t, "repulse");

    // Reset mid-operation aborts it
    fill_rand();
    t = cyc + 2;
    start_at(t);
    wait_cyc(t + 6); rst = 1'b1;
    wait_cyc(t + 7); rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_en", int'(c_wr_en), 0);
    chk("abort_wdata", int'(c_wr_data), 0);
    wait_cyc(t + 25);
    chk("abort_nwr", wq.size(), 4);
    if (wq.size() > 0) chk("abort_last_wr", int'(wq[wq.size()-1].cyc <= t + 6), 1);
    chk("abort_ndone", dq.size(), 0);
    run_full("post_abort");

    // Earliest restart right after a completed run
    fill_rand();
    compute_exp();
    t = cyc + 2;
    start_at(t);
    wait_cyc(t + 13);
    check_op(t, "b2b_first");
    start_at(t + 13);
    wait_cyc(t + 28);
    check_op(t + 13, "b2b_second");
    if (dq.size() > 0) chk("b2b_done25", dq[0], t + 25);

    for (int n = 0; n < 4; n++) begin
      fill_rand();
      run_full($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameter DW, default 8: signed operand width.
REQ-002 Parameter N, default 3: matrix dimension; only N=3 is supported.
REQ-003 Parameter OW, default 16: signed result width.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: reset; synchronous, active-high.
REQ-006 Port start, input, 1: single-cycle request to compute C = A x B.
REQ-007 Port a_rd_en, output, 1: read strobe for the A-row memory.
REQ-008 Port a_rd_addr, output, 2: row index i.
REQ-009 Port a_rd_data, input, 3*DW: signed row elements A[i][0..2]; [DW-1:0] = element 0.
REQ-010 Port b_rd_en, output, 1: read strobe for the B-column memory.
REQ-011 Port b_rd_addr, output, 2: column index j.
REQ-012 Port b_rd_data, input, 3*DW: signed column elements B[0..2][j]; [DW-1:0] = element 0.
REQ-013 Port c_wr_en, output, 1: result write strobe.
REQ-014 Port c_wr_addr, output, 4: result address = 3*i + j.
REQ-015 Port c_wr_data, output, OW: signed C[i][j].
REQ-016 Port busy, output, 1: high from the cycle after start acceptance until done.
REQ-017 Port done, output, 1: single-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE, start=1 in cycle t SHALL move the FSM to RUN; start in RUN, DRAIN or DONE is ignored.
REQ-020 In RUN, the block SHALL issue one read per cycle in cycles t+1..t+9, with a_rd_en = b_rd_en = 1 and (i,j) in row-major order, j fastest: (0,0),(0,1),...,(2,2).
REQ-021 After issuing (2,2), the FSM SHALL go to DRAIN, and remain there until the last write completes.
REQ-022 Read data SHALL be valid in the cycle after its read strobe; memory latency is fixed at 1 cycle.
REQ-023 C[i][j] SHALL equal A0*B0 + A1*B1 + A2*B2, computed with sign-extended DW x DW products and the sum truncated to OW bits (two's-complement wrap, no saturation).
REQ-024 The sum SHALL be registered, so c_wr_en/c_wr_addr/c_wr_data for a read issued in cycle k appear in cycle k+2; writes therefore occupy cycles t+3..t+11, one per cycle, with no gaps.
REQ-025 done SHALL pulse in cycle t+12 (state DONE), with busy=0 in that cycle.
REQ-026 The FSM SHALL return to IDLE in cycle t+13, and the earliest accepted restart is start in cycle t+13.
REQ-027 a_rd_en, b_rd_en and c_wr_en SHALL be 0 in every cycle outside the windows above; addresses and data are don't-care when their strobes are low.
REQ-028 c_wr_addr SHALL be delayed in step with the datapath, never recomputed from the live counters.

Reset
REQ-029 When rst=1 at a clock edge, the next state SHALL be IDLE with i = j = 0, pipeline valid bits cleared, and all outputs 0 (busy, done, strobes, addresses, c_wr_data).
REQ-030 rst SHALL override start in the same cycle.
REQ-031 Reset mid-operation SHALL abort the operation: no further write strobe and no done pulse are produced for the aborted operation.

Structure
REQ-032 The shared package matmul_pkg SHALL hold DW, N, OW, the state enum and the C-address width constant.
REQ-033 The dot-product datapath SHALL be one sub-module, dot3_pe (3 multipliers, adder tree, output register), instantiated once.
REQ-034 Sequencing (FSM, i/j counters, 2-stage valid/address pipeline) SHALL reside in matmul_ctrl.

Verification
REQ-035 A = identity, B = 1..9 row-major, start pulse -> nine writes at addr 0..8 with data 1..9 in cycles t+3..t+11, done at t+12.
REQ-036 All A and B = 127 -> every c_wr_data = -17149 (48387 wrapped to 16 bits).
REQ-037 All A and B = -128 -> every c_wr_data = -16384 (49152 wrapped).
REQ-038 start re-pulsed at t+5 and at t+12 -> ignored: exactly 9 writes and one done.
REQ-039 rst asserted at t+6 for one cycle -> no c_wr_en after t+6 and no done; a subsequent start runs a full, correct operation.
REQ-040 start at t+13 after a prior run -> a second full operation with done at t+25.
